// File: rtl/fp_add_arbiter.sv
// Round-robin front end that lets two requesters share one external
// single-precision adder: operands are registered, the sum is held until consumed.
module fp_add_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        req1_ready,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  input  logic [31:0] adder_s,
  input  logic        adder_overflow,
  input  logic        adder_underflow,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        last_grant_r;
  logic        owner_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic        rsp_valid_r;
  logic        rsp_id_r;
  logic [31:0] rsp_result_r;
  logic        rsp_overflow_r;
  logic        rsp_underflow_r;

  logic        idle_s;
  logic        winner_s;
  logic        grant0_s;
  logic        grant1_s;
  logic        accept_s;
  logic [31:0] win_a_s;
  logic [31:0] win_b_s;
  logic        win_sub_s;

  // Subtraction is expressed as addition with b's sign bit flipped; nothing else is touched,
  // so zeros, NaNs and infinities pass through bit-exact.
  function automatic logic [31:0] effective_b(input logic [31:0] b, input logic sub);
    logic [31:0] r;
    if (sub) begin
      r = {~b[31], b[30:0]};
    end else begin
      r = b;
    end
    return r;
  endfunction

  assign idle_s = (state_r == IDLE) && !rst;

  // Winner selection: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid && req1_valid) begin
      winner_s = ~last_grant_r;
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  assign grant0_s  = idle_s && req0_valid && !winner_s;
  assign grant1_s  = idle_s && req1_valid &&  winner_s;
  assign accept_s  = grant0_s || grant1_s;
  assign win_a_s   = winner_s ? req1_a   : req0_a;
  assign win_b_s   = winner_s ? req1_b   : req0_b;
  assign win_sub_s = winner_s ? req1_sub : req0_sub;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        state_next_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture and arbitration history, loaded only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r       <= 32'd0;
      op_b_r       <= 32'd0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      op_a_r       <= win_a_s;
      op_b_r       <= effective_b(win_b_s, win_sub_s);
      owner_r      <= winner_s;
      last_grant_r <= winner_s;
    end
  end

  // Response capture on the edge leaving EXEC; held until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r     <= 1'b0;
      rsp_id_r        <= 1'b0;
      rsp_result_r    <= 32'd0;
      rsp_overflow_r  <= 1'b0;
      rsp_underflow_r <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_valid_r     <= 1'b1;
      rsp_id_r        <= owner_r;
      rsp_result_r    <= adder_s;
      rsp_overflow_r  <= adder_overflow;
      rsp_underflow_r <= adder_underflow;
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_valid_r     <= 1'b0;
    end
  end

  assign req0_ready    = grant0_s;
  assign req1_ready    = grant1_s;
  assign adder_a       = op_a_r;
  assign adder_b       = op_b_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_id        = rsp_id_r;
  assign rsp_result    = rsp_result_r;
  assign rsp_overflow  = rsp_overflow_r;
  assign rsp_underflow = rsp_underflow_r;
  assign busy          = (state_r != IDLE) && !rst;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: a cycle-level reference model predicts grants,
// timing and responses; a separate monitor checks each presented response.
module tb_fp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] adder_a, adder_b, adder_s;
  logic        adder_overflow, adder_underflow;
  logic        rsp_valid, rsp_id, rsp_overflow, rsp_underflow;
  logic [31:0] rsp_result;
  logic        rsp_ready = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  fp_add_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(req1_ready),
    .adder_a(adder_a), .adder_b(adder_b), .adder_s(adder_s),
    .adder_overflow(adder_overflow), .adder_underflow(adder_underflow),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Stand-in for the external adder: exact sums for the directed vectors, an
  // asymmetric mixing function elsewhere so operand routing errors show up. {ovf, udf, sum}
  function automatic logic [33:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
    logic [33:0] r;
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) r = {2'b00, 32'h4040_0000};
    else if (a == 32'h4040_0000 && b == 32'hBF80_0000) r = {2'b00, 32'h4000_0000};
    else if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) r = {2'b10, 32'h7F80_0000};
    else r = {a[0] & b[1], a[2] ^ b[4], a + {b[15:0], b[31:16]}};
    return r;
  endfunction

  logic [33:0] add_out;
  assign add_out         = adder_fn(adder_a, adder_b);
  assign adder_s         = add_out[31:0];
  assign adder_underflow = add_out[32];
  assign adder_overflow  = add_out[33];

  typedef struct packed {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for work, 1 = adder settling, 2 = response held
  int          m_phase  = 0;
  logic        m_last   = 1'b1;
  logic        post_rst = 1'b0;
  logic        m_w, m_e0, m_e1, m_sub;
  logic [31:0] m_b;
  exp_t        cur;

  always @(negedge clk) begin : model
    if (rst) begin
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_ready1", req1_ready, 1'b0);
      m_phase  = 0;
      m_last   = 1'b1;
      post_rst = 1'b1;
      exp_q.delete();
    end else begin
      if (post_rst) begin
        chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("post_rst_rsp_id", rsp_id, 1'b0);
        chk("post_rst_rsp_result", rsp_result, 32'd0);
        chk1("post_rst_rsp_ovf", rsp_overflow, 1'b0);
        chk1("post_rst_rsp_udf", rsp_underflow, 1'b0);
        chk("post_rst_adder_a", adder_a, 32'd0);
        chk("post_rst_adder_b", adder_b, 32'd0);
        post_rst = 1'b0;
      end
      m_w  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      m_e0 = (m_phase == 0) && req0_valid && !m_w;
      m_e1 = (m_phase == 0) && req1_valid && m_w;
      chk1("busy", busy, m_phase != 0);
      chk1("rsp_valid", rsp_valid, m_phase == 2);
      chk1("req0_ready", req0_ready, m_e0);
      chk1("req1_ready", req1_ready, m_e1);
      if (m_phase == 1) begin
        chk("adder_a", adder_a, cur.a);
        chk("adder_b", adder_b, cur.b);
      end
      case (m_phase)
        0: if (m_e0 || m_e1) begin
          cur.id = m_w;
          cur.a  = m_w ? req1_a : req0_a;
          m_b    = m_w ? req1_b : req0_b;
          m_sub  = m_w ? req1_sub : req0_sub;
          cur.b  = m_sub ? (m_b ^ 32'h8000_0000) : m_b;
          {cur.ovf, cur.udf, cur.res} = adder_fn(cur.a, cur.b);
          exp_q.push_back(cur);
          m_last  = m_w;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  // Monitor: every presented response must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d result %h expected no response", rsp_id, rsp_result);
      end else begin
        chk1("rsp_id", rsp_id, exp_q[0].id);
        chk("rsp_result", rsp_result, exp_q[0].res);
        chk1("rsp_overflow", rsp_overflow, exp_q[0].ovf);
        chk1("rsp_underflow", rsp_underflow, exp_q[0].udf);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  logic acc0 = 1'b0, acc1 = 1'b0;
  logic rand_mode = 1'b0;

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = 32'h0000_0000;
      1: r = 32'h8000_0000;
      2: r = 32'h7F80_0000;
      3: r = 32'hFF80_0000;
      4: r = 32'h7FC0_0000;
      default: r = $urandom();
    endcase
    return r;
  endfunction

  task automatic cycle();
    @(negedge clk);
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (rand_mode) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_a = rand_operand(); req0_b = rand_operand(); req0_sub = 1'($urandom_range(0, 1));
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_a = rand_operand(); req1_b = rand_operand(); req1_sub = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_acc(input logic who, input string name);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(who ? acc1 : acc0) && n < 20);
    chk1(name, who ? acc1 : acc0, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      cycle();
      n++;
    end
    chk1(name, busy, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  logic order [3];
  int   n_acc;

  initial begin
    #1;
    do_reset(3);
    cycle();

    // Single add from requester 0, with latency checks
    req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_sub = 1'b0; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    wait_acc(1'b0, "r032_accept");
    req0_valid = 1'b0;
    chk("r032_adder_a", adder_a, 32'h3F80_0000);
    chk("r032_adder_b", adder_b, 32'h4000_0000);
    chk1("r032_no_early_valid", rsp_valid, 1'b0);
    cycle();
    chk1("r032_rsp_valid", rsp_valid, 1'b1);
    chk1("r032_rsp_id", rsp_id, 1'b0);
    chk("r032_rsp_result", rsp_result, 32'h4040_0000);
    chk1("r032_ovf", rsp_overflow, 1'b0);
    chk1("r032_udf", rsp_underflow, 1'b0);
    wait_idle("r032_idle");

    // Subtraction from requester 1
    req1_a = 32'h4040_0000; req1_b = 32'h3F80_0000; req1_sub = 1'b1; req1_valid = 1'b1;
    wait_acc(1'b1, "r033_accept");
    req1_valid = 1'b0;
    chk("r033_adder_b", adder_b, 32'hBF80_0000);
    cycle();
    chk1("r033_rsp_id", rsp_id, 1'b1);
    chk("r033_rsp_result", rsp_result, 32'h4000_0000);
    wait_idle("r033_idle");

    // Both held after reset: grants alternate 0, 1, 0
    do_reset(2);
    req0_a = 32'h1234_5678; req0_b = 32'h0BAD_F00D; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 32'hC0FF_EE00; req1_b = 32'h8000_0000; req1_sub = 1'b1; req1_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 3; i++) begin
      cycle();
      if (acc0) begin order[n_acc] = 1'b0; n_acc++; end
      else if (acc1) begin order[n_acc] = 1'b1; n_acc++; end
    end
    chk("r034_grant_count", n_acc, 32'd3);
    if (n_acc == 3) begin
      chk1("r034_first", order[0], 1'b0);
      chk1("r034_second", order[1], 1'b1);
      chk1("r034_third", order[2], 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("r034_idle");

    // Response held with rsp_ready low while requester 1 waits
    rsp_ready = 1'b0;
    req0_a = 32'h7FC0_0001; req0_b = 32'h8000_0000; req0_sub = 1'b1; req0_valid = 1'b1;
    wait_acc(1'b0, "r035_accept");
    req0_valid = 1'b0;
    req1_a = 32'h3F80_0000; req1_b = 32'hFF80_0000; req1_sub = 1'b0; req1_valid = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    chk1("r035_still_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    cycle();
    chk1("r035_idle_after_ready", busy, 1'b0);
    wait_acc(1'b1, "r035_req1_served");
    req1_valid = 1'b0;
    wait_idle("r035_idle");

    // Overflow flag is captured verbatim
    req0_a = 32'h7F7F_FFFF; req0_b = 32'h7F7F_FFFF; req0_sub = 1'b0; req0_valid = 1'b1;
    wait_acc(1'b0, "r036_accept");
    req0_valid = 1'b0;
    cycle();
    chk1("r036_ovf", rsp_overflow, 1'b1);
    chk1("r036_udf", rsp_underflow, 1'b0);
    chk("r036_result", rsp_result, 32'h7F80_0000);
    wait_idle("r036_idle");

    // Reset during EXEC discards the operation
    req0_a = 32'h4120_0000; req0_b = 32'h4110_0000; req0_sub = 1'b1; req0_valid = 1'b1;
    wait_acc(1'b0, "r037_accept");
    req0_valid = 1'b0;
    do_reset(1);
    cycle();
    chk1("r037_busy", busy, 1'b0);
    chk1("r037_rsp_valid", rsp_valid, 1'b0);
    chk("r037_rsp_result", rsp_result, 32'd0);
    for (int i = 0; i < 6; i++) cycle();

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 600; i++) cycle();
    rand_mode = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("drain_queue", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (32-bit IEEE 754 single precision).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-006 req0_sub  input  1  requester 0 op select (1 = a-b, 0 = a+b).
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_sub, req1_ready  same directions, widths and meaning for requester 1.
REQ-009 adder_a, adder_b  output  32 each  operands to the shared external ieee754_adder.
REQ-010 adder_s  input  32  sum from the shared adder.
REQ-011 adder_overflow, adder_underflow  input  1 each  flags from the shared adder.
REQ-012 rsp_valid  output  1  response held for the owning requester.
REQ-013 rsp_id  output  1  owning requester (0 or 1).
REQ-014 rsp_result  output  32  captured sum.
REQ-015 rsp_overflow, rsp_underflow  output  1 each  captured flags.
REQ-016 rsp_ready  input  1  response consumer accepts the response this cycle.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-019 In IDLE, the winner SHALL be chosen combinationally: only one valid -> that requester; both valid -> the requester not granted last (round-robin).
REQ-020 req<i>_ready SHALL be high only in IDLE, only for the winner, only while its valid is high; neither ready is ever high outside IDLE.
REQ-021 On a valid&&ready edge, operand registers SHALL load a and (sub ? {~b[31], b[30:0]} : b); owner id and last_grant SHALL update; state -> EXEC.
REQ-022 adder_a/adder_b SHALL be driven only from the operand registers, never combinationally from request ports.
REQ-023 In EXEC (one cycle, adder settling), on the edge leaving EXEC, adder_s/adder_overflow/adder_underflow SHALL be captured into the rsp_* registers; state -> RESP.
REQ-024 In RESP, rsp_valid SHALL be 1 and rsp_id, rsp_result and flags SHALL hold stable until rsp_ready is high.
REQ-025 RESP with rsp_ready high SHALL return to IDLE the next cycle; rsp_valid drops that edge; no new acceptance occurs in the same cycle as rsp_ready.
REQ-026 Latency: acceptance at edge N -> rsp_valid high from cycle N+2; minimum initiation interval is 3 cycles per operation.
REQ-027 Request ports SHALL be ignored (valid, a, b, sub) while state != IDLE; a requester holding valid is served once the FSM returns to IDLE.
REQ-028 Signed-zero, NaN and infinity operands SHALL pass through unaltered except the b sign flip for subtraction; no arithmetic is performed in this block.
REQ-029 Flags SHALL be captured verbatim; this block never generates overflow or underflow itself.

Reset
REQ-030 rst high at a rising edge SHALL force state IDLE, last_grant = 1 (requester 0 wins the first tie), operand registers 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_overflow 0, rsp_underflow 0; busy 0 and both ready 0 while rst is high.
REQ-031 Reset asserted during EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.

Verification
REQ-032 req0 a=3F800000, b=40000000, sub=0 alone -> req0_ready 1 cycle, rsp_valid at N+2 with rsp_id=0, rsp_result=40400000, flags 0.
REQ-033 req1 a=40400000, b=3F800000, sub=1 -> adder_b=BF800000, rsp_id=1, rsp_result=40000000.
REQ-034 After reset, req0 and req1 both valid and held -> req0 served first, then req1; with both still held a third op goes to req0 (alternation).
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_id, rsp_result stable all 5 cycles; req_ready stays 0; IDLE one cycle after rsp_ready rises.
REQ-036 req0 a=7F7FFFFF, b=7F7FFFFF with adder model driving adder_overflow=1 in EXEC -> rsp_overflow=1, rsp_underflow=0.
REQ-037 rst asserted in EXEC -> next cycle busy=0, rsp_valid=0, all rsp_* = 0, and no response for that op ever appears.
